// File: rtl/des_pkg.sv
// DES tables and pure helper functions shared by the iterative core and its round.
// Vectors are [N-1:0] with the MSB holding FIPS bit 1.
package des_pkg;

  typedef enum logic {IDLE = 1'b0, CRYPT = 1'b1} state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Each S-box is 64 nibbles, entry (row*16 + col) with the first entry in the top nibble.
  localparam logic [255:0] SBOX_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s_out;
    logic [5:0]  six;
    logic [5:0]  idx;
    x     = expand(r) ^ k;
    s_out = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[6'(47 - 6 * s) -: 6];
      idx = {six[5], six[0], six[4:1]};
      s_out[5'(31 - 4 * s) -: 4] = SBOX_T[3'(s)][8'(255 - 4 * idx) -: 4];
    end
    return perm_p(s_out);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    case (n)
      2'd1:    y = {x[26:0], x[27]};
      2'd2:    y = {x[25:0], x[27:26]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    case (n)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round including the C/D rotation for its subkey.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [27:0] c,
  input  logic [27:0] d,
  input  logic        mode,
  input  logic [3:0]  round,
  output logic [31:0] l_nx,
  output logic [31:0] r_nx,
  output logic [27:0] c_nx,
  output logic [27:0] d_nx
);

  logic [3:0]  rev_idx;
  logic [1:0]  shift;
  logic [47:0] subkey;

  // Decrypt walks the schedule backwards: C/D after PC1 already equal C16/D16,
  // so round 0 uses them as-is and later rounds undo shift (16 - round).
  always_comb begin
    rev_idx = 4'd0 - round;
    shift   = 2'(SHIFT_T[round]);
    c_nx    = rotl28(c, shift);
    d_nx    = rotl28(d, shift);
    if (mode) begin
      shift = (round == 4'd0) ? 2'd0 : 2'(SHIFT_T[rev_idx]);
      c_nx  = rotr28(c, shift);
      d_nx  = rotr28(d, shift);
    end
  end

  assign subkey = pc2({c_nx, d_nx});
  assign l_nx   = r;
  assign r_nx   = l ^ f(r, subkey);

endmodule

// File: rtl/des_iter.sv
// Iterative DES core: ROUNDS_PER_CYC Feistel rounds per clock (legal 1, 2, 4),
// one block in flight, result announced by a one-cycle valid_o pulse.
module des_iter
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYC = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mode_i,
  input  logic [63:0] key_i,
  input  logic [63:0] data_i,
  input  logic        valid_i,
  output logic        accept_o,
  output logic [63:0] data_o,
  output logic        valid_o,
  output logic        dbg_state_o
);

  localparam logic [3:0] STEP = 4'(ROUNDS_PER_CYC);
  localparam logic [3:0] LAST = 4'(16 - ROUNDS_PER_CYC);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        mode_q;
  logic        take;
  logic [63:0] ip_blk;
  logic [55:0] pc1_key;

  logic [31:0] l_ch [ROUNDS_PER_CYC+1];
  logic [31:0] r_ch [ROUNDS_PER_CYC+1];
  logic [27:0] c_ch [ROUNDS_PER_CYC+1];
  logic [27:0] d_ch [ROUNDS_PER_CYC+1];

  // Handshake: a block transfers on any rising edge with valid_i && accept_o;
  // accept_o comes from the registered state only, never from valid_i.
  assign accept_o    = (state == IDLE);
  assign dbg_state_o = state;
  assign take        = valid_i && accept_o;
  assign ip_blk      = ip(data_i);
  assign pc1_key     = pc1(key_i);

  assign l_ch[0] = l_q;
  assign r_ch[0] = r_q;
  assign c_ch[0] = c_q;
  assign d_ch[0] = d_q;

  for (genvar g = 0; g < ROUNDS_PER_CYC; g++) begin : g_round
    des_round u_round (
      .l     (l_ch[g]),
      .r     (r_ch[g]),
      .c     (c_ch[g]),
      .d     (d_ch[g]),
      .mode  (mode_q),
      .round (cnt + 4'(g)),
      .l_nx  (l_ch[g+1]),
      .r_nx  (r_ch[g+1]),
      .c_nx  (c_ch[g+1]),
      .d_nx  (d_ch[g+1])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid_i) state_nx = CRYPT;
      CRYPT:   if (cnt == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt     <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      mode_q  <= 1'b0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (take) begin
        {l_q, r_q} <= ip_blk;
        {c_q, d_q} <= pc1_key;
        mode_q     <= mode_i;
        cnt        <= '0;
      end else if (state == CRYPT) begin
        l_q <= l_ch[ROUNDS_PER_CYC];
        r_q <= r_ch[ROUNDS_PER_CYC];
        c_q <= c_ch[ROUNDS_PER_CYC];
        d_q <= d_ch[ROUNDS_PER_CYC];
        cnt <= cnt + STEP;
        if (cnt == LAST) begin
          data_o  <= fp({r_ch[ROUNDS_PER_CYC], l_ch[ROUNDS_PER_CYC]});
          valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_iter.sv
// Bench for des_iter: scoreboard of expected blocks, independent DES model with a
// precomputed subkey table, KATs, back-to-back NIST plaintexts, random and reset cases.
module tb_des_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_i;
  logic        valid_i;
  logic [63:0] key_i;
  logic [63:0] data_i;
  logic        accept_o;
  logic [63:0] data_o;
  logic        valid_o;
  logic        dbg_state;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          chk_acc = 1'b1;
  logic [63:0] exp_q[$];
  int          tx_q[$];

  int t_ip[$]  = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                   62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                   57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                   61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  int t_fp[$]  = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                   38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                   36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                   34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  int t_e[$]   = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                   12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                   24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int t_p[$]   = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                   2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int t_pc1[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                   10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                   63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                   14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int t_pc2[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                   26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                   51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int sh[16]   = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  logic [255:0] sb[8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  des_iter #(.ROUNDS_PER_CYC(1)) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .mode_i      (mode_i),
    .key_i       (key_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .accept_o    (accept_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] permute(input logic [63:0] src, input int n_src, input int tbl[$]);
    logic [63:0] res;
    res = '0;
    foreach (tbl[i]) res = (res << 1) | ((src >> (n_src - tbl[i])) & 64'd1);
    return res;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] o;
    int six, idx;
    x = 48'(permute({32'd0, r}, 32, t_e)) ^ k;
    o = '0;
    for (int s = 0; s < 8; s++) begin
      six = int'((x >> (42 - 6 * s)) & 48'h3F);
      idx = ((six >> 5) & 1) * 32 + (six & 1) * 16 + ((six >> 1) & 15);
      o = (o << 4) | 32'((sb[s] >> (252 - 4 * idx)) & 256'hF);
    end
    return 32'(permute({32'd0, o}, 32, t_p));
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks[16];
    logic [63:0] b;
    logic [31:0] l, r, t;
    cd = 56'(permute(key, 64, t_pc1));
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < sh[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = 48'(permute({8'd0, c, d}, 56, t_pc2));
    end
    b = permute(blk, 64, t_ip);
    l = b[63:32];
    r = b[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ m_f(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    return permute({r, l}, 64, t_fp);
  endfunction

  // ---------------- check helpers ----------------
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Waits for accept_o at a falling edge, presents the block, records the expectation.
  task automatic send(input logic [63:0] k, input logic [63:0] d, input logic m,
                      input logic [63:0] e, input bit hold, output int tx);
    int n;
    n = 0;
    while (accept_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_int("accept_wait", int'(accept_o === 1'b1), 1);
    key_i   = k;
    data_i  = d;
    mode_i  = m;
    valid_i = 1'b1;
    exp_q.push_back(e);
    tx_q.push_back(cyc + 1);
    tx = cyc + 1;
    @(negedge clk);
    if (hold) begin
      key_i  = {$urandom, $urandom};
      data_i = {$urandom, $urandom};
      mode_i = ~m;
    end else begin
      valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    valid_i = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_int("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int acc_run;
    acc_run = 0;
    forever begin
      @(negedge clk);
      if (!rst && valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_valid: got data_o %h with valid_o, want no output", data_o);
        end else begin
          check64("data_o", data_o, exp_q.pop_front());
          check_int("latency", cyc - tx_q.pop_front(), 16);
        end
      end
      if (rst || !chk_acc) acc_run = 0;
      else if (accept_o === 1'b0) acc_run++;
      else if (acc_run != 0) begin
        check_int("accept_low_cycles", acc_run, 16);
        acc_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [63:0] k, d, p, ct;
    logic        m;
    bit          hold;
    int          tx, prev;

    rst = 1'b1; valid_i = 1'b0; mode_i = 1'b0; key_i = '0; data_i = '0;
    repeat (3) @(negedge clk);
    check64("reset_accept_o", 64'(accept_o), 64'd1);
    check64("reset_valid_o", 64'(valid_o), 64'd0);
    check64("reset_data_o", data_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check64("release_accept_o", 64'(accept_o), 64'd1);

    send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 1'b0, tx);
    send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, 1'b0, tx);
    send(64'h0101010101010101, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7, 1'b0, tx);
    send(64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7, 1'b0, tx);
    send(64'h0101010101010101, 64'h8000000000000000, 1'b0, 64'h95F8A5E5DD31D900, 1'b0, tx);
    drain();

    // Back-to-back NIST variable plaintext, encrypt then decrypt, junk inputs during CRYPT.
    k = 64'h0101010101010101;
    prev = 0;
    for (int i = 0; i < 128; i++) begin
      p = 64'h8000000000000000 >> (i % 64);
      ct = des_ref(k, p, 1'b0);
      if (i < 64) send(k, p, 1'b0, ct, 1'b1, tx);
      else        send(k, ct, 1'b1, p, 1'b1, tx);
      if (i > 0) check_int("tx_spacing", tx - prev, 17);
      prev = tx;
    end
    drain();

    for (int i = 0; i < 40; i++) begin
      k = {$urandom, $urandom};
      d = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      send(k, d, m, des_ref(k, d, m), hold, tx);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Asynchronous reset in the middle of a block.
    k = 64'h0E329232EA6D0D73;
    d = 64'h8787878787878787;
    send(k, d, 1'b0, des_ref(k, d, 1'b0), 1'b0, tx);
    repeat (4) @(negedge clk);
    #2;
    chk_acc = 1'b0;
    rst = 1'b1;
    #1;
    check64("abort_data_o", data_o, 64'd0);
    check64("abort_valid_o", 64'(valid_o), 64'd0);
    exp_q.delete();
    tx_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check64("abort_accept_o", 64'(accept_o), 64'd1);
    repeat (25) @(negedge clk);
    chk_acc = 1'b1;
    send(k, d, 1'b1, des_ref(k, d, 1'b1), 1'b0, tx);
    send(k, d, 1'b0, des_ref(k, d, 1'b0), 1'b0, tx);
    drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_iter.md
Name: des_iter

Overview:
Iterative DES encryption/decryption core: one Feistel round per clock, with a ready/valid input handshake.
It is the area-lean responder on the same mode/key/data/valid interface the pipelined des core exposes, for designs that do not need one-block-per-cycle throughput.
Typical sources are a mode wrapper (ECB/CBC) or a KAT sequencer; the result is a single-cycle valid pulse.

Parameters:
- ROUNDS_PER_CYC, 1, Feistel rounds evaluated per clock; legal values 1, 2, 4. Latency = 16/ROUNDS_PER_CYC cycles.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  asynchronous reset, active-high
- mode_i  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- key_i  in  64 [0:63]  DES key, bit 0 = FIPS bit 1 (MSB); parity bits 7,15,...,63 ignored; sampled on accept
- data_i  in  64 [0:63]  plaintext/ciphertext block, same bit order; sampled on accept
- valid_i  in  1  source offers a block
- accept_o  out  1  core idle and able to take a block this cycle
- data_o  out  64 [0:63]  result block; holds the last result until the next completion
- valid_o  out  1  one-cycle pulse, data_o valid

Behaviour:
- Reset (async, active-high): state = IDLE, round counter = 0, data_o = 0, valid_o = 0, accept_o = 1 after reset is released. Reset mid-operation aborts the block silently; no valid_o is produced.
- Two-state FSM: IDLE, CRYPT.
- accept_o = (state == IDLE), decoded from the registered state only; it does not depend on valid_i.
- Transfer occurs on a rising edge where valid_i && accept_o. At that edge the core loads:
  - L/R <= IP(data_i)
  - C/D <= PC1(key_i)
  - mode register <= mode_i
  - counter <= 0
  - state <= CRYPT
- In CRYPT, each edge performs ROUNDS_PER_CYC rounds; the counter advances by ROUNDS_PER_CYC.
- Key schedule, encrypt: rotate C/D left by the FIPS shift schedule (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1) before PC2 of each round.
- Key schedule, decrypt: round 1 uses unrotated C/D; later rounds rotate right by the schedule taken in reverse order. Subkeys therefore appear K16..K1 with no stored key table.
- On the edge completing round 16:
  - data_o <= FP(R16 || L16) (swap undone)
  - valid_o <= 1 for exactly one cycle
  - state <= IDLE
- Latency with ROUNDS_PER_CYC = 1: valid_o is high in the 16th cycle after the transfer edge; sustained throughput is 1 block per 17 cycles.
- accept_o is high in the same cycle valid_o is high, so the next block can transfer in that cycle.
- Input changes while in CRYPT are ignored; valid_i held high while accept_o is low is not an error.
- Round and counter wrap: the counter counts 0..15 and is reset on every transfer; no wrap is visible outside the core.
- Identical keys/data in successive blocks produce identical outputs; the core keeps no state between blocks.

Decomposition:
- Package des_pkg holds:
  - permutation tables IP, FP, E, P, PC1, PC2
  - 8 S-box tables
  - shift schedule
  - pure functions ip(), fp(), pc1(), pc2(), f(R, K)
  - FSM state type (IDLE, CRYPT)
- One sub-module, des_round: combinational, inputs L, R, C, D, mode, round index; outputs L', R', C', D' (includes the key rotation). des_iter instantiates ROUNDS_PER_CYC copies in a chain.

Test Plan:
- Encrypt, key 133457799BBCDFF1, data 0123456789ABCDEF, mode 0 -> data_o 85E813540F0AB405, valid_o one cycle, 16 cycles after transfer.
- Decrypt, same key, data 85E813540F0AB405, mode 1 -> data_o 0123456789ABCDEF.
- Parity ignored: key 0101010101010101 and key 0000000000000000, each with data 0000000000000000 -> both give 8CA64DE9C1B123A7. NIST variable-plaintext: key 0101010101010101, data 8000000000000000 -> 95F8A5E5DD31D900.
- Back-to-back with valid_i held high: 128 NIST variable-plaintext vectors -> a transfer every 17 cycles, accept_o low for exactly 16 cycles per block, all outputs match in order. Changing data_i during CRYPT does not alter the result.
- Reset mid-block: assert reset_i asynchronously 5 cycles after transfer -> valid_o and data_o are 0 immediately, accept_o is 1 after release, no stray valid_o. The next block computes correctly.
